// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and parameter helpers for the SPI slave
package spi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  // Sampling happens on the rising sclk edge when CPOL and CPHA agree
  // (mode 0: leading edge rises; mode 3: trailing edge rises).
  function automatic bit sample_on_rise(input bit cpol, input bit cpha);
    return cpol == cpha;
  endfunction

  function automatic bit width_ok(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - N-stage synchroniser with rise/fall pulse detection
module spi_sync_edge #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Synchroniser chain plus one delay flop so edges compare two settled samples
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave_core.sv
// rtl/spi_slave_core.sv - oversampled full-duplex SPI slave, all modes, streaming words
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_dat,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rcvd_p_dat,
  output logic                  tx_done,
  output logic                  frame_err
);

  if (!width_ok(DATA_WIDTH) || (SYNC_STAGES < 2)) begin : g_bad_param
    $error("spi_slave_core: DATA_WIDTH must be 2..32 and SYNC_STAGES >= 2");
  end

  localparam int             CW          = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]  LAST        = CW'(DATA_WIDTH - 1);
  localparam bit             SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

  logic w_unused_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_mosi_lvl, w_unused_mosi_rise, w_unused_mosi_fall;
  logic w_sample, w_shift, w_last;

  state_t                r_state;
  logic [CW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_rx_shift;
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic [DATA_WIDTH-1:0] r_tx_hold;
  logic [DATA_WIDTH-1:0] r_rcvd;
  logic                  r_word_done;
  logic                  r_tx_done;
  logic                  r_frame_err;
  logic                  r_miso;
  logic                  r_tx_ready;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
    .i_clk(clk), .i_rst(rst), .i_d(sclk),
    .o_level(w_unused_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .i_clk(clk), .i_rst(rst), .i_d(cs),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(clk), .i_rst(rst), .i_d(mosi),
    .o_level(w_mosi_lvl), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
  );

  assign w_sample = SAMPLE_RISE ? w_sclk_rise : w_sclk_fall;
  assign w_shift  = SAMPLE_RISE ? w_sclk_fall : w_sclk_rise;
  assign w_last   = (r_bit_cnt == LAST);

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v);
    return MSB_FIRST ? v[DATA_WIDTH-1] : v[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v);
    return MSB_FIRST ? {v[DATA_WIDTH-2:0], 1'b0} : {1'b0, v[DATA_WIDTH-1:1]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] v,
                                                     input logic b);
    return MSB_FIRST ? {v[DATA_WIDTH-2:0], b} : {b, v[DATA_WIDTH-1:1]};
  endfunction

  // Transfer FSM: word assembly, miso shifting, holding register and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_tx_hold   <= '0;
      r_rcvd      <= '0;
      r_word_done <= 1'b0;
      r_tx_done   <= 1'b0;
      r_frame_err <= 1'b0;
      r_miso      <= 1'b0;
      r_tx_ready  <= 1'b1;
    end else begin
      // Completion is published one clk after the final sample, even if cs already rose
      r_tx_done   <= r_word_done;
      r_frame_err <= 1'b0;
      r_word_done <= 1'b0;
      if (r_word_done) begin
        r_rcvd <= r_rx_shift;
      end

      if (tx_load && r_tx_ready) begin
        r_tx_hold <= tx_dat;
      end

      case (r_state)
        IDLE: begin
          r_bit_cnt  <= '0;
          r_tx_ready <= 1'b1;
          if (w_cs_fall) begin
            r_state <= XFER;
            if (!CPHA) begin
              r_miso     <= first_bit(r_tx_hold);
              r_tx_shift <= shift_out(r_tx_hold);
            end else begin
              r_tx_shift <= r_tx_hold;
            end
          end
        end

        XFER: begin
          if (w_sample) begin
            r_rx_shift <= shift_in(r_rx_shift, w_mosi_lvl);
            if (w_last) begin
              r_bit_cnt   <= '0;
              r_word_done <= 1'b1;
              r_tx_shift  <= r_tx_hold;
              r_tx_ready  <= 1'b1;
            end else begin
              r_bit_cnt  <= r_bit_cnt + CW'(1);
              r_tx_ready <= 1'b0;
            end
          end else if (w_shift) begin
            r_miso     <= first_bit(r_tx_shift);
            r_tx_shift <= shift_out(r_tx_shift);
          end

          // A final sample in the same clk as cs rising completes the word cleanly
          if (w_cs_rise) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_tx_ready <= 1'b1;
            if (w_sample ? !w_last : (r_bit_cnt != '0)) begin
              r_frame_err <= 1'b1;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign miso       = r_miso;
  assign miso_oe    = ~w_cs_lvl;
  assign tx_ready   = r_tx_ready;
  assign rcvd_p_dat = r_rcvd;
  assign tx_done    = r_tx_done;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_spi_slave_core.sv
// tb/tb_spi_slave_core.sv - scoreboard bench for spi_slave_core in three configurations
module tb_spi_slave_core;

  localparam int HALF = 80;
  // instance 0: mode 0 MSB w8; instance 1: mode 3 LSB w8; instance 2: mode 1 MSB w16
  localparam bit [2:0] CPOL_V = 3'b010;
  localparam bit [2:0] CPHA_V = 3'b110;
  localparam bit [2:0] MSB_V  = 3'b101;

  typedef struct {
    int          inst;
    bit          done;
    bit          ferr;
    logic [15:0] data;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_e;
  logic [15:0] last_rcvd [3];
  int          n_checks = 0;
  int          n_err    = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk_p [3];
  logic        cs_p [3];
  logic        mosi_p [3];
  logic        tx_load_p [3];
  logic [7:0]  tx_dat0, tx_dat1;
  logic [15:0] tx_dat2;
  logic        miso_w [3];
  logic        oe_w [3];
  logic        rdy_w [3];
  logic        done_w [3];
  logic        ferr_w [3];
  logic [7:0]  rcvd0, rcvd1;
  logic [15:0] rcvd2;
  logic [15:0] rcvd_w [3];

  always #5 clk = ~clk;

  always_comb begin
    rcvd_w[0] = {8'h00, rcvd0};
    rcvd_w[1] = {8'h00, rcvd1};
    rcvd_w[2] = rcvd2;
  end

  spi_slave_core #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u0 (
    .clk(clk), .rst(rst), .sclk(sclk_p[0]), .cs(cs_p[0]), .mosi(mosi_p[0]),
    .miso(miso_w[0]), .miso_oe(oe_w[0]), .tx_dat(tx_dat0), .tx_load(tx_load_p[0]),
    .tx_ready(rdy_w[0]), .rcvd_p_dat(rcvd0), .tx_done(done_w[0]), .frame_err(ferr_w[0])
  );

  spi_slave_core #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) u1 (
    .clk(clk), .rst(rst), .sclk(sclk_p[1]), .cs(cs_p[1]), .mosi(mosi_p[1]),
    .miso(miso_w[1]), .miso_oe(oe_w[1]), .tx_dat(tx_dat1), .tx_load(tx_load_p[1]),
    .tx_ready(rdy_w[1]), .rcvd_p_dat(rcvd1), .tx_done(done_w[1]), .frame_err(ferr_w[1])
  );

  spi_slave_core #(.DATA_WIDTH(16), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u2 (
    .clk(clk), .rst(rst), .sclk(sclk_p[2]), .cs(cs_p[2]), .mosi(mosi_p[2]),
    .miso(miso_w[2]), .miso_oe(oe_w[2]), .tx_dat(tx_dat2), .tx_load(tx_load_p[2]),
    .tx_ready(rdy_w[2]), .rcvd_p_dat(rcvd2), .tx_done(done_w[2]), .frame_err(ferr_w[2])
  );

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic expect_word(input int d, input logic [15:0] v);
    ev_t e;
    e.inst = d; e.done = 1'b1; e.ferr = 1'b0; e.data = v;
    exp_q.push_back(e);
    last_rcvd[d] = v;
  endtask

  task automatic expect_ferr(input int d);
    ev_t e;
    e.inst = d; e.done = 1'b0; e.ferr = 1'b1; e.data = last_rcvd[d];
    exp_q.push_back(e);
  endtask

  task automatic load(input int d, input logic [15:0] v);
    @(posedge clk); #1;
    case (d)
      0: tx_dat0 = v[7:0];
      1: tx_dat1 = v[7:0];
      default: tx_dat2 = v;
    endcase
    tx_load_p[d] = 1'b1;
    @(posedge clk); #1;
    tx_load_p[d] = 1'b0;
  endtask

  task automatic master_word(input int d, input int w, input int nbits,
                             input logic [15:0] mo, output logic [15:0] mi);
    int bi;
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      bi = MSB_V[d] ? (w - 1 - i) : i;
      if (!CPHA_V[d]) begin
        mosi_p[d] = mo[bi];
        #(HALF);
        sclk_p[d] = ~CPOL_V[d];
        mi[bi] = miso_w[d];
        #(HALF);
        sclk_p[d] = CPOL_V[d];
      end else begin
        sclk_p[d] = ~CPOL_V[d];
        mosi_p[d] = mo[bi];
        #(HALF);
        sclk_p[d] = CPOL_V[d];
        mi[bi] = miso_w[d];
        #(HALF);
      end
    end
  endtask

  task automatic frame(input int d, input int nbits, input logic [15:0] mo,
                       output logic [15:0] mi);
    int w;
    w = (d == 2) ? 16 : 8;
    cs_p[d] = 1'b0;
    #(HALF);
    master_word(d, w, nbits, mo, mi);
    #(HALF);
    cs_p[d] = 1'b1;
    #(HALF * 2);
  endtask

  task automatic wait_done(input int d);
    int i;
    i = 0;
    while (!done_w[d] && i < 2000) begin
      @(negedge clk);
      i++;
    end
    if (i >= 2000) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_done timeout inst=%0d got=no_tx_done want=tx_done", d);
    end
  endtask

  task automatic check_reset_outputs(input int d);
    check($sformatf("rst%0d_rcvd", d), rcvd_w[d], 16'h0);
    check($sformatf("rst%0d_tx_done", d), 16'(done_w[d]), 16'h0);
    check($sformatf("rst%0d_frame_err", d), 16'(ferr_w[d]), 16'h0);
    check($sformatf("rst%0d_miso", d), 16'(miso_w[d]), 16'h0);
    check($sformatf("rst%0d_miso_oe", d), 16'(oe_w[d]), 16'h0);
    check($sformatf("rst%0d_tx_ready", d), 16'(rdy_w[d]), 16'h1);
  endtask

  // Monitor: every tx_done / frame_err pulse is matched against the next expected event
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (done_w[d] === 1'b1 || ferr_w[d] === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected inst=%0d got done=%b ferr=%b data=%h want no_event",
                   d, done_w[d], ferr_w[d], rcvd_w[d]);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.inst != d || mon_e.done != done_w[d] || mon_e.ferr != ferr_w[d] ||
              mon_e.data !== rcvd_w[d]) begin
            n_err++;
            $display("FAIL sb_event got inst=%0d done=%b ferr=%b data=%h want inst=%0d done=%b ferr=%b data=%h",
                     d, done_w[d], ferr_w[d], rcvd_w[d],
                     mon_e.inst, mon_e.done, mon_e.ferr, mon_e.data);
          end
        end
      end
    end
  end

  initial begin
    #(2000000);
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mi;
    logic [15:0] got [3];
    logic [15:0] wd [3];
    logic [15:0] rl [2];

    for (int d = 0; d < 3; d++) begin
      sclk_p[d]    = CPOL_V[d];
      cs_p[d]      = 1'b1;
      mosi_p[d]    = 1'b0;
      tx_load_p[d] = 1'b0;
      last_rcvd[d] = '0;
    end
    tx_dat0 = '0; tx_dat1 = '0; tx_dat2 = '0;

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check_reset_outputs(d);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // mode 0 MSB-first single word
    load(0, 16'h003C);
    expect_word(0, 16'h00A5);
    frame(0, 8, 16'h00A5, mi);
    check("t1_master_rx", mi, 16'h003C);

    // mode 3 LSB-first single word
    load(1, 16'h007E);
    expect_word(1, 16'h0081);
    frame(1, 8, 16'h0081, mi);
    check("t2_master_rx", mi, 16'h007E);

    // streaming three words under one cs, holding register refilled after each tx_done
    wd[0] = 16'h0011; wd[1] = 16'h0022; wd[2] = 16'h0033;
    rl[0] = 16'h00B2; rl[1] = 16'h00C3;
    load(0, 16'h00A1);
    for (int k = 0; k < 3; k++) expect_word(0, wd[k]);
    fork
      begin
        cs_p[0] = 1'b0;
        #(HALF);
        for (int k = 0; k < 3; k++) begin
          master_word(0, 8, 8, wd[k], mi);
          got[k] = mi;
        end
        #(HALF);
        cs_p[0] = 1'b1;
        #(HALF * 2);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          wait_done(0);
          load(0, rl[k]);
        end
      end
    join
    check("t3_master_rx0", got[0], 16'h00A1);
    check("t3_master_rx1", got[1], 16'h00A1);
    check("t3_master_rx2", got[2], 16'h00B2);

    // abort after 5 bits, then a clean word
    expect_ferr(0);
    frame(0, 5, 16'h00FF, mi);
    load(0, 16'h0099);
    expect_word(0, 16'h005A);
    frame(0, 8, 16'h005A, mi);
    check("t4_master_rx", mi, 16'h0099);

    // reset in the middle of a word
    load(0, 16'h0055);
    cs_p[0] = 1'b0;
    #(HALF);
    master_word(0, 8, 3, 16'h00C3, mi);
    @(posedge clk); #1;
    rst = 1'b1;
    cs_p[0] = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs(0);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) last_rcvd[d] = '0;
    repeat (20) @(posedge clk);
    expect_word(0, 16'h00C3);
    frame(0, 8, 16'h00C3, mi);
    check("t5_master_rx_hold_cleared", mi, 16'h0000);

    // 16-bit mode 1; a load attempted mid-word must be dropped
    load(2, 16'h1234);
    expect_word(2, 16'hBEEF);
    fork
      frame(2, 16, 16'hBEEF, mi);
      begin
        repeat (60) @(posedge clk);
        #1;
        check("t6_tx_ready_low", 16'(rdy_w[2]), 16'h0);
        check("t6_miso_oe_high", 16'(oe_w[2]), 16'h1);
        tx_dat2 = 16'hFFFF;
        tx_load_p[2] = 1'b1;
        @(posedge clk); #1;
        tx_load_p[2] = 1'b0;
      end
    join
    check("t6_master_rx", mi, 16'h1234);
    expect_word(2, 16'h0F0F);
    frame(2, 16, 16'h0F0F, mi);
    check("t6_ignored_load", mi, 16'h1234);

    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
    check("sb_drained", 16'(exp_q.size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
